ram_sync_param: RTL and testbench

Parametrised single-port synchronous RAM; next generation of the fixed 8x8 RAM. Adds configurable width/depth, per-byte write enables, a selectable read latency with a read-valid strobe, and a hardware clear engine that zero-fills (or pattern-fills) the array after reset or on request. Serves as the generic on-chip scratch memory for the datapath blocks in this design.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_clear_ctrl.sv | 57 +++++
 rtl/ram_sync_param.sv | 92 +++++++++
 tb/tb_ram_sync_param.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised synchronous scratch RAM.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ram_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // Number of 8-bit lanes in a data word.
  function automatic int unsigned byte_lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: sweeps every address once after reset or on request,
// holding busy high so the array ignores normal accesses meanwhile.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ram_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  // Busy is registered alongside the state so it is glitch-free at the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with byte enables, 1- or 2-cycle
// read latency with a valid strobe, and a hardware clear engine.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 3,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              write_enable,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] byte_enable,
  input  logic                              read_enable,
  input  logic                              clear_req,
  output logic                              busy,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              read_valid
);

  localparam int unsigned NUM_BYTES = byte_lanes(DATA_WIDTH);
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rd_acc_c;
  logic                  wr_acc_c;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_vld_q;

  ram_clear_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign rd_acc_c = read_enable & ~busy;
  assign wr_acc_c = write_enable & ~busy;

  // Array has no reset; the clear engine owns initialisation.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= CLEAR_VALUE;
    end else if (wr_acc_c) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (byte_enable[i]) mem_q[address][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  // First read stage samples the array before the same-edge write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc_c;
      if (rd_acc_c) rd_data_q <= mem_q[address];
    end
  end

  if (READ_LATENCY >= RD_LAT_MAX) begin : g_lat2
    logic [DATA_WIDTH-1:0] out_q;
    logic                  vld_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= rd_vld_q;
        if (rd_vld_q) out_q <= rd_data_q;
      end
    end

    assign data_out   = out_q;
    assign read_valid = vld_q;
  end else begin : g_lat1
    assign data_out   = rd_data_q;
    assign read_valid = rd_vld_q;
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: 8-bit/lat1, 16-bit/lat1 and 8-bit/lat2 instances
// share stimulus; a reference memory feeds per-instance expected-read queues.
module tb_ram_sync_param;

  typedef struct packed {
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic [15:0] data_in;
  logic        write_enable;
  logic [1:0]  byte_enable;
  logic        read_enable;
  logic        clear_req;

  logic        busy8, busy16, busy2;
  logic [7:0]  dout8, dout2;
  logic [15:0] dout16;
  logic        vld8, vld16, vld2;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        busy_m;
  logic [15:0] mem_m [8];
  logic [7:0]  last8, last2;
  logic [15:0] last16;
  exp_t        q8[$], q16[$], q2[$];
  exp_t        em;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(1)) u_d8 (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in[7:0]),
    .write_enable(write_enable), .byte_enable(byte_enable[0:0]),
    .read_enable(read_enable), .clear_req(clear_req), .busy(busy8),
    .data_out(dout8), .read_valid(vld8));

  ram_sync_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_LATENCY(1)) u_d16 (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write_enable(write_enable), .byte_enable(byte_enable),
    .read_enable(read_enable), .clear_req(clear_req), .busy(busy16),
    .data_out(dout16), .read_valid(vld16));

  ram_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in[7:0]),
    .write_enable(write_enable), .byte_enable(byte_enable[0:0]),
    .read_enable(read_enable), .clear_req(clear_req), .busy(busy2),
    .data_out(dout2), .read_valid(vld2));

  // Output monitor: every valid pops the scoreboard; otherwise data_out must hold.
  always @(negedge clk) begin
    n_cmp++;
    if (vld8) begin
      if (q8.size() == 0) begin
        n_err++; $display("FAIL d8_spurious_valid got=%h required=no_valid", dout8);
      end else begin
        em = q8.pop_front();
        if (dout8 !== em.data[7:0] || cyc != em.due) begin
          n_err++; $display("FAIL d8_read got=%h@%0d required=%h@%0d", dout8, cyc, em.data[7:0], em.due);
        end
        last8 = em.data[7:0];
      end
    end else if (dout8 !== last8) begin
      n_err++; $display("FAIL d8_hold got=%h required=%h", dout8, last8);
    end

    n_cmp++;
    if (vld16) begin
      if (q16.size() == 0) begin
        n_err++; $display("FAIL d16_spurious_valid got=%h required=no_valid", dout16);
      end else begin
        em = q16.pop_front();
        if (dout16 !== em.data || cyc != em.due) begin
          n_err++; $display("FAIL d16_read got=%h@%0d required=%h@%0d", dout16, cyc, em.data, em.due);
        end
        last16 = em.data;
      end
    end else if (dout16 !== last16) begin
      n_err++; $display("FAIL d16_hold got=%h required=%h", dout16, last16);
    end

    n_cmp++;
    if (vld2) begin
      if (q2.size() == 0) begin
        n_err++; $display("FAIL l2_spurious_valid got=%h required=no_valid", dout2);
      end else begin
        em = q2.pop_front();
        if (dout2 !== em.data[7:0] || cyc != em.due) begin
          n_err++; $display("FAIL l2_read got=%h@%0d required=%h@%0d", dout2, cyc, em.data[7:0], em.due);
        end
        last2 = em.data[7:0];
      end
    end else if (dout2 !== last2) begin
      n_err++; $display("FAIL l2_hold got=%h required=%h", dout2, last2);
    end
  end

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic cycle_access(input logic we, input logic re, input logic [2:0] a,
                              input logic [15:0] d, input logic [1:0] be, input logic clr);
    exp_t e;
    write_enable = we; read_enable = re; address = a;
    data_in = d; byte_enable = be; clear_req = clr;
    if (!busy_m) begin
      if (re) begin
        e.data = mem_m[a];
        e.due  = cyc + 1;
        q8.push_back(e);
        q16.push_back(e);
        e.due  = cyc + 2;
        q2.push_back(e);
      end
      if (we) begin
        for (int i = 0; i < 2; i++) if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0; clear_req = 1'b0;
    if (clr && !busy_m) begin
      busy_m = 1'b1;
      for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy8, busy16, busy2} !== 3'b111 || dout8 !== 8'h00 || dout16 !== 16'h0000 ||
        {vld8, vld16, vld2} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_state got busy=%b dout=%h/%h/%h vld=%b required busy=111 dout=0 vld=000",
               {busy8, busy16, busy2}, dout8, dout16, dout2, {vld8, vld16, vld2});
    end
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while ((busy8 || busy16 || busy2) && n < 20);
    n_cmp++;
    if (n != 8 || {busy8, busy16, busy2} !== 3'b000) begin
      n_err++; $display("FAIL reset_busy_len got=%0d required=8", n);
    end
    busy_m = 1'b0;
  endtask

  task automatic test_clear_readback();
    for (int a = 0; a < 8; a++) cycle_access(1'b0, 1'b1, 3'(a), 16'h0, 2'b11, 1'b0);
    idle(3);
    n_cmp++;
    if (q8.size() != 0 || q16.size() != 0 || q2.size() != 0) begin
      n_err++; $display("FAIL clear_readback_pending got=%0d/%0d/%0d required=0/0/0",
                        q8.size(), q16.size(), q2.size());
    end
  endtask

  task automatic test_back_to_back();
    cycle_access(1'b1, 1'b0, 3'd1, 16'h00A5, 2'b11, 1'b0);
    cycle_access(1'b1, 1'b0, 3'd2, 16'h003C, 2'b11, 1'b0);
    cycle_access(1'b1, 1'b0, 3'd4, 16'h00F0, 2'b11, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd1, 16'h0, 2'b11, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd2, 16'h0, 2'b11, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd4, 16'h0, 2'b11, 1'b0);
    idle(4);
    n_cmp++;
    if (dout8 !== 8'hF0 || dout2 !== 8'hF0) begin
      n_err++; $display("FAIL b2b_hold got=%h/%h required=f0/f0", dout8, dout2);
    end
  endtask

  task automatic test_byte_enable();
    cycle_access(1'b1, 1'b0, 3'd3, 16'h1234, 2'b11, 1'b0);
    cycle_access(1'b1, 1'b0, 3'd3, 16'hABCD, 2'b01, 1'b0);
    cycle_access(1'b1, 1'b0, 3'd3, 16'hFFFF, 2'b00, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd3, 16'h0, 2'b11, 1'b0);
    idle(3);
    n_cmp++;
    if (dout16 !== 16'h12CD || dout8 !== 8'hCD) begin
      n_err++; $display("FAIL byte_enable got=%h/%h required=12cd/cd", dout16, dout8);
    end
  endtask

  task automatic test_read_write_same();
    cycle_access(1'b1, 1'b0, 3'd5, 16'h0011, 2'b11, 1'b0);
    cycle_access(1'b1, 1'b1, 3'd5, 16'h0022, 2'b11, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd5, 16'h0, 2'b11, 1'b0);
    idle(3);
  endtask

  task automatic test_clear();
    int n;
    cycle_access(1'b1, 1'b0, 3'd6, 16'h005A, 2'b11, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd6, 16'h0, 2'b11, 1'b1);
    n = 1;
    while ((busy8 || busy16 || busy2) && n < 30) begin
      cycle_access(1'b1, 1'b1, 3'd6, 16'hFFFF, 2'b11, 1'b1);
      n++;
    end
    n_cmp++;
    if (n != 9) begin
      n_err++; $display("FAIL clear_busy_len got=%0d required=9", n);
    end
    busy_m = 1'b0;
    cycle_access(1'b0, 1'b1, 3'd6, 16'h0, 2'b11, 1'b0);
    cycle_access(1'b0, 1'b1, 3'd1, 16'h0, 2'b11, 1'b0);
    idle(3);
  endtask

  task automatic test_reset_mid_read();
    exp_t e;
    int   n;
    cycle_access(1'b1, 1'b0, 3'd1, 16'h0077, 2'b11, 1'b0);
    read_enable = 1'b1; address = 3'd1;
    e.data = mem_m[1];
    e.due  = cyc + 1;
    q8.push_back(e);
    q16.push_back(e);
    e.due  = cyc + 2;
    q2.push_back(e);
    @(posedge clk);
    @(negedge clk);
    read_enable = 1'b0;
    n_cmp++;
    if (vld2 !== 1'b0) begin
      n_err++; $display("FAIL l2_early_valid got=%b required=0", vld2);
    end
    #1;
    n_cmp++;
    if (q8.size() != 0 || q16.size() != 0) begin
      n_err++; $display("FAIL lat1_before_reset pending got=%0d/%0d required=0/0", q8.size(), q16.size());
    end
    reset = 1'b0;
    q2.delete();
    last8 = 8'h00; last16 = 16'h0000; last2 = 8'h00;
    busy_m = 1'b1;
    for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({busy8, busy16, busy2} !== 3'b111 || vld2 !== 1'b0 || dout2 !== 8'h00) begin
        n_err++; $display("FAIL midread_reset got busy=%b vld2=%b dout2=%h required busy=111 vld2=0 dout2=00",
                          {busy8, busy16, busy2}, vld2, dout2);
      end
    end
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while ((busy8 || busy16 || busy2) && n < 20);
    n_cmp++;
    if (n != 8) begin
      n_err++; $display("FAIL midread_busy_len got=%0d required=8", n);
    end
    busy_m = 1'b0;
    cycle_access(1'b0, 1'b1, 3'd1, 16'h0, 2'b11, 1'b0);
    idle(4);
  endtask

  initial begin
    reset = 1'b0; address = '0; data_in = '0; write_enable = 1'b0;
    byte_enable = '0; read_enable = 1'b0; clear_req = 1'b0;
    busy_m = 1'b1;
    last8 = 8'h00; last16 = 16'h0000; last2 = 8'h00;
    for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
    test_reset();
    test_clear_readback();
    test_back_to_back();
    test_byte_enable();
    test_read_write_same();
    test_clear();
    test_reset_mid_read();
    n_cmp++;
    if (q8.size() != 0 || q16.size() != 0 || q2.size() != 0) begin
      n_err++; $display("FAIL final_pending got=%0d/%0d/%0d required=0/0/0", q8.size(), q16.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
